// File: rtl/p4_router_port_id_mapper.sv
// p4_router_port_id_mapper
// Runtime-programmable translation between RTL port indices and P4 port IDs
// carried on VNP4 user metadata {ing_port, egr_spec}.
//   ingress channel: ing_port (RTL index) -> P4 ID, direct lookup
//   egress channel : egr_spec (P4 ID) -> RTL index, search of all enabled
//                    entries, lowest matching index wins
// Each channel is one valid/ready register stage (latency 1, 1 beat/cycle),
// and the two channels never stall each other.
// Optional feature: define P4_ROUTER_PORT_MAP_MISS_CNT_EN to build the
// saturating miss counters; otherwise ing_miss_cnt/egr_miss_cnt read zero.
module p4_router_port_id_mapper #(
  parameter int NUM_PORTS         = 11,
  parameter int ING_PORT_ID_WIDTH = 8,
  parameter int EGR_SPEC_ID_WIDTH = 8,
  parameter int MISS_P4_ID        = 255,
  parameter int MISS_RTL_ID       = 255,
  parameter int CNT_WIDTH         = 16,
  localparam int IDX_WIDTH        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int MD_WIDTH         = ING_PORT_ID_WIDTH + EGR_SPEC_ID_WIDTH
) (
  input  logic                         clk,
  input  logic                         sresetn,
  // ingress channel
  input  logic [MD_WIDTH-1:0]          ing_in_md,
  input  logic                         ing_in_valid,
  output logic                         ing_in_ready,
  output logic [MD_WIDTH-1:0]          ing_out_md,
  output logic                         ing_out_valid,
  input  logic                         ing_out_ready,
  output logic                         ing_out_miss,
  // egress channel
  input  logic [MD_WIDTH-1:0]          egr_in_md,
  input  logic                         egr_in_valid,
  output logic                         egr_in_ready,
  output logic [MD_WIDTH-1:0]          egr_out_md,
  output logic                         egr_out_valid,
  input  logic                         egr_out_ready,
  output logic                         egr_out_miss,
  // table configuration
  input  logic                         cfg_wr_en,
  input  logic [IDX_WIDTH-1:0]         cfg_wr_idx,
  input  logic [ING_PORT_ID_WIDTH-1:0] cfg_wr_p4_id,
  input  logic                         cfg_wr_vld,
  // miss statistics
  output logic [CNT_WIDTH-1:0]         ing_miss_cnt,
  output logic [CNT_WIDTH-1:0]         egr_miss_cnt
);

  localparam int CMP_WIDTH = (ING_PORT_ID_WIDTH > EGR_SPEC_ID_WIDTH) ?
                             ING_PORT_ID_WIDTH : EGR_SPEC_ID_WIDTH;

  logic [ING_PORT_ID_WIDTH-1:0] tbl_p4_id [NUM_PORTS];
  logic [NUM_PORTS-1:0]         tbl_vld;

  logic [ING_PORT_ID_WIDTH-1:0] ing_port;
  logic [EGR_SPEC_ID_WIDTH-1:0] ing_egr_spec;
  logic [ING_PORT_ID_WIDTH-1:0] ing_p4_id;
  logic                         ing_miss;
  logic                         ing_load;

  logic [ING_PORT_ID_WIDTH-1:0] egr_ing_port;
  logic [EGR_SPEC_ID_WIDTH-1:0] egr_spec;
  logic [EGR_SPEC_ID_WIDTH-1:0] egr_rtl_idx;
  logic                         egr_miss;
  logic                         egr_load;

  // Translation table: identity map on reset, one entry written per cfg strobe.
  // NOTE: the table is a small flop array rather than a RAM, so it is reset
  // explicitly; sequential state always uses non-blocking '<='.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        tbl_p4_id[i] <= ING_PORT_ID_WIDTH'(i);
        tbl_vld[i]   <= 1'b1;
      end
    end else if (cfg_wr_en) begin
      // an out-of-range index matches no entry and is dropped
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (int'(cfg_wr_idx) == i) begin
          tbl_p4_id[i] <= cfg_wr_p4_id;
          tbl_vld[i]   <= cfg_wr_vld;
        end
      end
    end
  end

  assign ing_port     = ing_in_md[MD_WIDTH-1 -: ING_PORT_ID_WIDTH];
  assign ing_egr_spec = ing_in_md[EGR_SPEC_ID_WIDTH-1:0];
  assign egr_ing_port = egr_in_md[MD_WIDTH-1 -: ING_PORT_ID_WIDTH];
  assign egr_spec     = egr_in_md[EGR_SPEC_ID_WIDTH-1:0];

  // Ingress lookup: index out of range or disabled entry is a miss.
  // NOTE: combinational blocks assign every output a default first, so no
  // latch can be inferred, and use blocking '='.
  always_comb begin
    ing_p4_id = ING_PORT_ID_WIDTH'(MISS_P4_ID);
    ing_miss  = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (int'(ing_port) == i && tbl_vld[i]) begin
        ing_p4_id = tbl_p4_id[i];
        ing_miss  = 1'b0;
      end
    end
  end

  // Egress reverse lookup: scan high to low so the lowest matching index is
  // the last one written and therefore wins on duplicate P4 IDs.
  always_comb begin
    egr_rtl_idx = EGR_SPEC_ID_WIDTH'(MISS_RTL_ID);
    egr_miss    = 1'b1;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (tbl_vld[i] && CMP_WIDTH'(tbl_p4_id[i]) == CMP_WIDTH'(egr_spec)) begin
        egr_rtl_idx = EGR_SPEC_ID_WIDTH'(i);
        egr_miss    = 1'b0;
      end
    end
  end

  assign ing_in_ready = !ing_out_valid || ing_out_ready;
  assign ing_load     = ing_in_valid && ing_in_ready;
  assign egr_in_ready = !egr_out_valid || egr_out_ready;
  assign egr_load     = egr_in_valid && egr_in_ready;

  // Ingress output stage: load on accept, hold while stalled, empty on drain.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      ing_out_valid <= 1'b0;
      ing_out_md    <= '0;
      ing_out_miss  <= 1'b0;
    end else if (ing_load) begin
      ing_out_valid <= 1'b1;
      ing_out_md    <= {ing_p4_id, ing_egr_spec};
      ing_out_miss  <= ing_miss;
    end else if (ing_out_ready) begin
      ing_out_valid <= 1'b0;
    end
  end

  // Egress output stage: same handshake as ingress, independent of it.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      egr_out_valid <= 1'b0;
      egr_out_md    <= '0;
      egr_out_miss  <= 1'b0;
    end else if (egr_load) begin
      egr_out_valid <= 1'b1;
      egr_out_md    <= {egr_ing_port, egr_rtl_idx};
      egr_out_miss  <= egr_miss;
    end else if (egr_out_ready) begin
      egr_out_valid <= 1'b0;
    end
  end

`ifdef P4_ROUTER_PORT_MAP_MISS_CNT_EN
  logic [CNT_WIDTH-1:0] ing_cnt_q;
  logic [CNT_WIDTH-1:0] egr_cnt_q;

  // Miss counters: one step per miss beat loaded into the output, stick at all-ones.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      ing_cnt_q <= '0;
      egr_cnt_q <= '0;
    end else begin
      if (ing_load && ing_miss && ing_cnt_q != '1) begin
        ing_cnt_q <= ing_cnt_q + CNT_WIDTH'(1);
      end
      if (egr_load && egr_miss && egr_cnt_q != '1) begin
        egr_cnt_q <= egr_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign ing_miss_cnt = ing_cnt_q;
  assign egr_miss_cnt = egr_cnt_q;
`else
  assign ing_miss_cnt = '0;
  assign egr_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_p4_router_port_id_mapper.sv
// Self-checking bench for p4_router_port_id_mapper (default parameters).
// Phases: reset state, directed vector table, mid-stream reset, identity
// recheck, egress back-pressure, randomized traffic against a reference
// model with per-channel scoreboards, and counter saturation when
// P4_ROUTER_PORT_MAP_MISS_CNT_EN is defined.
module tb_p4_router_port_id_mapper;

  localparam int NP = 11;

`ifdef P4_ROUTER_PORT_MAP_MISS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        sresetn;
  logic [15:0] ing_in_md, ing_out_md, egr_in_md, egr_out_md;
  logic        ing_in_valid, ing_in_ready, ing_out_valid, ing_out_ready, ing_out_miss;
  logic        egr_in_valid, egr_in_ready, egr_out_valid, egr_out_ready, egr_out_miss;
  logic        cfg_wr_en, cfg_wr_vld;
  logic [3:0]  cfg_wr_idx;
  logic [7:0]  cfg_wr_p4_id;
  logic [15:0] ing_miss_cnt, egr_miss_cnt;

  p4_router_port_id_mapper dut (
    .clk           (clk),
    .sresetn       (sresetn),
    .ing_in_md     (ing_in_md),
    .ing_in_valid  (ing_in_valid),
    .ing_in_ready  (ing_in_ready),
    .ing_out_md    (ing_out_md),
    .ing_out_valid (ing_out_valid),
    .ing_out_ready (ing_out_ready),
    .ing_out_miss  (ing_out_miss),
    .egr_in_md     (egr_in_md),
    .egr_in_valid  (egr_in_valid),
    .egr_in_ready  (egr_in_ready),
    .egr_out_md    (egr_out_md),
    .egr_out_valid (egr_out_valid),
    .egr_out_ready (egr_out_ready),
    .egr_out_miss  (egr_out_miss),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_idx    (cfg_wr_idx),
    .cfg_wr_p4_id  (cfg_wr_p4_id),
    .cfg_wr_vld    (cfg_wr_vld),
    .ing_miss_cnt  (ing_miss_cnt),
    .egr_miss_cnt  (egr_miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // ---------------- reference model: table + lookup rules ----------------
  logic [7:0] m_p4  [NP];
  logic       m_vld [NP];

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_p4[i]  = 8'(i);
      m_vld[i] = 1'b1;
    end
  endtask

  task automatic model_write(input logic en, input logic [3:0] idx, input logic [7:0] p4, input logic vld);
    int k;
    k = int'(idx);
    if (en && k < NP) begin
      m_p4[k]  = p4;
      m_vld[k] = vld;
    end
  endtask

  // returns {miss, p4_id}
  function automatic logic [8:0] ref_ing(input logic [7:0] port);
    int p;
    p = int'(port);
    if (p < NP && m_vld[p]) return {1'b0, m_p4[p]};
    return {1'b1, 8'd255};
  endfunction

  // returns {miss, rtl_index}; first (lowest) enabled match wins
  function automatic logic [8:0] ref_egr(input logic [7:0] spec);
    for (int i = 0; i < NP; i++) begin
      if (m_vld[i] && m_p4[i] == spec) return {1'b0, 8'(i)};
    end
    return {1'b1, 8'd255};
  endfunction

  // ---------------- scoreboards ----------------
  logic [16:0] ing_q [$];   // {miss, md} expected at the output, in order
  logic [16:0] egr_q [$];
  int          ing_cnt_m, egr_cnt_m;

  // One clock of traffic. Entered and left #1 after a rising edge.
  task automatic cycle(input logic iv, input logic [15:0] imd, input logic ir,
                       input logic ev, input logic [15:0] emd, input logic er,
                       input logic cen, input logic [3:0] cidx, input logic [7:0] cp4, input logic cvld,
                       output logic ing_acc, output logic egr_acc);
    logic [8:0] r;
    logic       ing_rdy_exp, egr_rdy_exp;
    check("ing_out_valid", ing_out_valid, ing_q.size() != 0);
    if (ing_q.size() != 0) check("ing_out_miss_md", {ing_out_miss, ing_out_md}, ing_q[0]);
    check("egr_out_valid", egr_out_valid, egr_q.size() != 0);
    if (egr_q.size() != 0) check("egr_out_miss_md", {egr_out_miss, egr_out_md}, egr_q[0]);
    check("ing_miss_cnt", ing_miss_cnt, CNT_EN ? 64'(ing_cnt_m) : 64'd0);
    check("egr_miss_cnt", egr_miss_cnt, CNT_EN ? 64'(egr_cnt_m) : 64'd0);

    ing_in_valid = iv;  ing_in_md = imd;  ing_out_ready = ir;
    egr_in_valid = ev;  egr_in_md = emd;  egr_out_ready = er;
    cfg_wr_en = cen;  cfg_wr_idx = cidx;  cfg_wr_p4_id = cp4;  cfg_wr_vld = cvld;
    #1;
    ing_rdy_exp = (ing_q.size() == 0) || ir;
    egr_rdy_exp = (egr_q.size() == 0) || er;
    check("ing_in_ready", ing_in_ready, ing_rdy_exp);
    check("egr_in_ready", egr_in_ready, egr_rdy_exp);

    if (ing_q.size() != 0 && ir) void'(ing_q.pop_front());
    if (egr_q.size() != 0 && er) void'(egr_q.pop_front());
    ing_acc = iv && ing_rdy_exp;
    egr_acc = ev && egr_rdy_exp;
    if (ing_acc) begin
      r = ref_ing(imd[15:8]);
      ing_q.push_back({r[8], r[7:0], imd[7:0]});
      if (r[8] && ing_cnt_m < 65535) ing_cnt_m++;
    end
    if (egr_acc) begin
      r = ref_egr(emd[7:0]);
      egr_q.push_back({r[8], emd[15:8], r[7:0]});
      if (r[8] && egr_cnt_m < 65535) egr_cnt_m++;
    end
    model_write(cen, cidx, cp4, cvld);   // same-cycle lookups used the old entry
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        cfg_en;
    logic [3:0]  cfg_idx;
    logic [7:0]  cfg_p4;
    logic        cfg_vld;
    logic [15:0] ing_md;
    logic [15:0] egr_md;
    logic [15:0] exp_ing_md;
    logic        exp_ing_miss;
    logic [15:0] exp_egr_md;
    logic        exp_egr_miss;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  logic ia, ea;
  int   exp_ing_cnt, exp_egr_cnt, is_n, es_n;

  initial begin
    //            cfg en idx  p4     vld   ing_md    egr_md    exp_ing   m     exp_egr   m
    vecs[0]  = '{1'b0, 4'd0,  8'd0,   1'b0, 16'h0307, 16'h0203, 16'h0307, 1'b0, 16'h0203, 1'b0};
    vecs[1]  = '{1'b1, 4'd3,  8'd40,  1'b1, 16'h0305, 16'h0228, 16'h0305, 1'b0, 16'h02FF, 1'b1};
    vecs[2]  = '{1'b0, 4'd0,  8'd0,   1'b0, 16'h0305, 16'h0228, 16'h2805, 1'b0, 16'h0203, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  8'd0,   1'b0, 16'h0100, 16'h0263, 16'h0100, 1'b0, 16'h02FF, 1'b1};
    vecs[4]  = '{1'b1, 4'd0,  8'd0,   1'b0, 16'h0009, 16'h0400, 16'h0009, 1'b0, 16'h0400, 1'b0};
    vecs[5]  = '{1'b0, 4'd0,  8'd0,   1'b0, 16'h0009, 16'h0400, 16'hFF09, 1'b1, 16'h04FF, 1'b1};
    vecs[6]  = '{1'b0, 4'd0,  8'd0,   1'b0, 16'h0C01, 16'h0603, 16'hFF01, 1'b1, 16'h06FF, 1'b1};
    vecs[7]  = '{1'b1, 4'd15, 8'd77,  1'b1, 16'h0A02, 16'h010A, 16'h0A02, 1'b0, 16'h010A, 1'b0};
    vecs[8]  = '{1'b1, 4'd7,  8'd5,   1'b1, 16'h0703, 16'h014D, 16'h0703, 1'b0, 16'h01FF, 1'b1};
    vecs[9]  = '{1'b0, 4'd0,  8'd0,   1'b0, 16'h0703, 16'h0005, 16'h0503, 1'b0, 16'h0005, 1'b0};
    vecs[10] = '{1'b1, 4'd5,  8'd200, 1'b1, 16'h0504, 16'h0005, 16'h0504, 1'b0, 16'h0005, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  8'd0,   1'b0, 16'h0504, 16'h0005, 16'hC804, 1'b0, 16'h0007, 1'b0};
    vecs[12] = '{1'b0, 4'd0,  8'd0,   1'b0, 16'h0B08, 16'h03C8, 16'hFF08, 1'b1, 16'h0305, 1'b0};
    vecs[13] = '{1'b0, 4'd0,  8'd0,   1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

    // ---- reset state (inputs active, reset must dominate) ----
    sresetn = 1'b0;
    ing_in_valid = 1'b1;  ing_in_md = 16'h0307;  ing_out_ready = 1'b0;
    egr_in_valid = 1'b1;  egr_in_md = 16'h0203;  egr_out_ready = 1'b0;
    cfg_wr_en = 1'b0;  cfg_wr_idx = 4'd0;  cfg_wr_p4_id = 8'd0;  cfg_wr_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ing_out_valid", ing_out_valid, 1'b0);
    check("rst egr_out_valid", egr_out_valid, 1'b0);
    check("rst ing_out_md", ing_out_md, 16'h0000);
    check("rst egr_out_md", egr_out_md, 16'h0000);
    check("rst ing_out_miss", ing_out_miss, 1'b0);
    check("rst egr_out_miss", egr_out_miss, 1'b0);
    check("rst ing_in_ready", ing_in_ready, 1'b1);
    check("rst egr_in_ready", egr_in_ready, 1'b1);
    check("rst ing_miss_cnt", ing_miss_cnt, 16'h0000);
    check("rst egr_miss_cnt", egr_miss_cnt, 16'h0000);
    sresetn = 1'b1;

    // ---- directed table: one beat per channel per cycle, no back-pressure ----
    exp_ing_cnt = 0;
    exp_egr_cnt = 0;
    for (int k = 0; k < NVEC; k++) begin
      cfg_wr_en = vecs[k].cfg_en;  cfg_wr_idx = vecs[k].cfg_idx;
      cfg_wr_p4_id = vecs[k].cfg_p4;  cfg_wr_vld = vecs[k].cfg_vld;
      ing_in_valid = 1'b1;  ing_in_md = vecs[k].ing_md;  ing_out_ready = 1'b1;
      egr_in_valid = 1'b1;  egr_in_md = vecs[k].egr_md;  egr_out_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_ing_cnt += int'(vecs[k].exp_ing_miss);
      exp_egr_cnt += int'(vecs[k].exp_egr_miss);
      check($sformatf("vec%0d ing_out_valid", k), ing_out_valid, 1'b1);
      check($sformatf("vec%0d ing_out_md", k), ing_out_md, vecs[k].exp_ing_md);
      check($sformatf("vec%0d ing_out_miss", k), ing_out_miss, vecs[k].exp_ing_miss);
      check($sformatf("vec%0d egr_out_valid", k), egr_out_valid, 1'b1);
      check($sformatf("vec%0d egr_out_md", k), egr_out_md, vecs[k].exp_egr_md);
      check($sformatf("vec%0d egr_out_miss", k), egr_out_miss, vecs[k].exp_egr_miss);
      check($sformatf("vec%0d ing_miss_cnt", k), ing_miss_cnt, CNT_EN ? 64'(exp_ing_cnt) : 64'd0);
      check($sformatf("vec%0d egr_miss_cnt", k), egr_miss_cnt, CNT_EN ? 64'(exp_egr_cnt) : 64'd0);
    end

    // ---- reset mid-stream: in-flight beats dropped, table back to identity ----
    cfg_wr_en = 1'b0;
    sresetn = 1'b0;
    @(posedge clk);
    #1;
    check("midrst ing_out_valid", ing_out_valid, 1'b0);
    check("midrst egr_out_valid", egr_out_valid, 1'b0);
    check("midrst ing_out_md", ing_out_md, 16'h0000);
    check("midrst egr_out_md", egr_out_md, 16'h0000);
    check("midrst ing_miss_cnt", ing_miss_cnt, 16'h0000);
    check("midrst egr_miss_cnt", egr_miss_cnt, 16'h0000);
    sresetn = 1'b1;
    ing_in_valid = 1'b0;
    egr_in_valid = 1'b0;
    model_reset();
    ing_q.delete();
    egr_q.delete();
    ing_cnt_m = 0;
    egr_cnt_m = 0;

    // identity restored: entries 0,3,5,7 were all reprogrammed above
    cycle(1, 16'h0703, 1, 1, 16'h0228, 1, 0, 4'd0, 8'd0, 0, ia, ea);
    cycle(1, 16'h0009, 1, 1, 16'h0005, 1, 0, 4'd0, 8'd0, 0, ia, ea);
    cycle(1, 16'h0305, 1, 1, 16'h0100, 1, 0, 4'd0, 8'd0, 0, ia, ea);
    cycle(0, 16'h0000, 1, 0, 16'h0000, 1, 0, 4'd0, 8'd0, 0, ia, ea);

    // ---- egress stalled for 5 cycles while both sources keep streaming ----
    is_n = 0;
    es_n = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1, {8'(is_n % 13), 8'(is_n)}, 1,
            1, {8'(es_n), 8'(es_n % 13)}, !(c >= 1 && c <= 5),
            0, 4'd0, 8'd0, 0, ia, ea);
      if (ia) is_n++;
      if (ea) es_n++;
    end
    for (int c = 0; c < 3; c++) cycle(0, 16'h0000, 1, 0, 16'h0000, 1, 0, 4'd0, 8'd0, 0, ia, ea);

    // ---- randomized traffic, back-pressure and table writes ----
    for (int c = 0; c < 2000; c++) begin
      cycle($urandom_range(0, 3) != 0, {8'($urandom_range(0, 15)), 8'($urandom)}, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, {8'($urandom), 8'($urandom_range(0, 15))}, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), $urandom_range(0, 4) != 0,
            ia, ea);
    end
    for (int c = 0; c < 4; c++) cycle(0, 16'h0000, 1, 0, 16'h0000, 1, 0, 4'd0, 8'd0, 0, ia, ea);

    // ---- counter saturation: 2^16+3 misses on both channels ----
    if (CNT_EN) begin
      ing_in_valid = 1'b1;  ing_in_md = 16'h0C00;  ing_out_ready = 1'b1;
      egr_in_valid = 1'b1;  egr_in_md = 16'h00FF;  egr_out_ready = 1'b1;
      cfg_wr_en = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("sat ing_miss_cnt step", ing_miss_cnt, 64'((ing_cnt_m + 10 > 65535) ? 65535 : ing_cnt_m + 10));
      check("sat egr_miss_cnt step", egr_miss_cnt, 64'((egr_cnt_m + 10 > 65535) ? 65535 : egr_cnt_m + 10));
      repeat (65536 + 3 - 10) @(posedge clk);
      #1;
      check("sat ing_miss_cnt", ing_miss_cnt, 16'hFFFF);
      check("sat egr_miss_cnt", egr_miss_cnt, 16'hFFFF);
      check("sat ing_out_miss", ing_out_miss, 1'b1);
      check("sat egr_out_md", egr_out_md, 16'h00FF);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
